// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// instr_sequencer_pkg: shared state encoding, datapath widths and opcode field values.
// Rev 1.0
package instr_sequencer_pkg;

  localparam int INSTR_W  = 16;
  localparam int RESULT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam logic [1:0] OPC_R = 2'b00;
  localparam logic [1:0] OPC_I = 2'b01;
  localparam logic [1:0] OPC_L = 2'b10;
  localparam logic [1:0] OPC_W = 2'b11;

  // Bytes arrive low first, so the held byte forms the low half.
  function automatic logic [INSTR_W-1:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_mem.sv
`default_nettype none
// instr_mem: DEPTH x 16 program store, synchronous write, asynchronous read, no reset.
// Rev 1.0
module instr_mem
  import instr_sequencer_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// instr_sequencer: loads a byte-stream program into instr_mem and replays it to the core,
// one registered instruction per cycle, capturing the core result. Rev 1.0
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_start_i,
  input  logic                load_done_i,
  input  logic [7:0]          byte_in_i,
  input  logic                byte_valid_i,
  input  logic                start_i,
  input  logic                hold_i,
  input  logic                abort_i,
  input  logic [RESULT_W-1:0] result_in_i,
  output logic [INSTR_W-1:0]  instr_out_o,
  output logic                instr_valid_o,
  output logic [AW-1:0]       pc_o,
  output logic [AW:0]         prog_len_o,
  output logic [RESULT_W-1:0] last_result_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                overflow_o
);

  seq_state_e          state_q;
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       pc_q;
  logic                phase_q;
  logic [7:0]          hold_byte_q;
  logic [AW:0]         prog_len_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                instr_valid_q;
  logic [RESULT_W-1:0] last_result_q;
  logic                done_q;
  logic                overflow_q;

  logic                mem_full;
  logic                mem_we;
  logic                last_instr;
  logic [AW-1:0]       rd_addr;
  logic [INSTR_W-1:0]  rd_data;
  logic [INSTR_W-1:0]  wr_data;

  assign mem_full   = (prog_len_q == (AW+1)'(DEPTH));
  assign mem_we     = (state_q == ST_LOAD) && !load_done_i && byte_valid_i && phase_q && !mem_full;
  assign wr_data    = pack_word(byte_in_i, hold_byte_q);
  assign last_instr = ({1'b0, pc_q} == (prog_len_q - (AW+1)'(1)));
  // Outside RUN the only word ever fetched is word 0, on start.
  assign rd_addr    = (state_q == ST_RUN) ? (pc_q + AW'(1)) : '0;

  instr_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      pc_q          <= '0;
      phase_q       <= 1'b0;
      hold_byte_q   <= '0;
      prog_len_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      last_result_q <= '0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (load_start_i) begin
            wr_ptr_q   <= '0;
            phase_q    <= 1'b0;
            prog_len_q <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            state_q    <= ST_LOAD;
          end else if (start_i) begin
            if (prog_len_q != '0) begin
              pc_q          <= '0;
              instr_q       <= rd_data;
              instr_valid_q <= 1'b1;
              done_q        <= 1'b0;
              state_q       <= ST_RUN;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          if (load_done_i) begin
            phase_q <= 1'b0;
            state_q <= ST_IDLE;
          end else if (byte_valid_i) begin
            if (mem_full) begin
              overflow_q <= 1'b1;
            end else if (!phase_q) begin
              hold_byte_q <= byte_in_i;
              phase_q     <= 1'b1;
            end else begin
              wr_ptr_q   <= wr_ptr_q + AW'(1);
              prog_len_q <= prog_len_q + (AW+1)'(1);
              phase_q    <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_q          <= '0;
            state_q       <= ST_IDLE;
          end else if (!hold_i) begin
            last_result_q <= result_in_i;
            if (last_instr) begin
              instr_q       <= '0;
              instr_valid_q <= 1'b0;
              done_q        <= 1'b1;
              state_q       <= ST_DONE;
            end else begin
              pc_q    <= pc_q + AW'(1);
              instr_q <= rd_data;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_out_o   = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign pc_o          = pc_q;
  assign prog_len_o    = prog_len_q;
  assign last_result_o = last_result_q;
  assign busy_o        = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done_o        = done_q;
  assign overflow_o    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// tb_instr_sequencer: randomized scoreboard bench against a list-level program model.
// Rev 1.0
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0, load_done = 1'b0, byte_valid = 1'b0;
  logic [7:0]    byte_in = '0;
  logic          start = 1'b0, hold = 1'b0, abort = 1'b0;
  logic [7:0]    result_in;
  logic [15:0]   instr_out;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic [AW:0]   prog_len;
  logic [7:0]    last_result;
  logic          busy, done, overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] pc;
    logic [15:0]   w;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  done_q[$];
  logic [7:0]  load_bytes[$];
  logic [15:0] mw[$];
  logic [7:0]  model_last = '0;
  bit          model_done = 1'b0;

  instr_sequencer #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_start_i (load_start),
    .load_done_i  (load_done),
    .byte_in_i    (byte_in),
    .byte_valid_i (byte_valid),
    .start_i      (start),
    .hold_i       (hold),
    .abort_i      (abort),
    .result_in_i  (result_in),
    .instr_out_o  (instr_out),
    .instr_valid_o(instr_valid),
    .pc_o         (pc),
    .prog_len_o   (prog_len),
    .last_result_o(last_result),
    .busy_o       (busy),
    .done_o       (done),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  // Stand-in for the core: any fixed combinational function of the instruction.
  function automatic logic [7:0] core_f(input logic [15:0] w);
    return w[7:0] ^ {w[3:0], w[15:12]} ^ 8'h3C;
  endfunction

  assign result_in = core_f(instr_out);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per executed instruction and per done rise.
  initial begin
    bit   prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (instr_valid && !hold && !abort) begin
          check("exp_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("instr_out", instr_out, e.w);
            check("pc", pc, e.pc);
          end
        end
        if (done && !prev_done) begin
          check("done_pending", done_q.size() != 0, 1);
          if (done_q.size() != 0) begin
            check("last_result", last_result, done_q.pop_front());
            check("valid_at_done", instr_valid, 0);
          end
        end
      end
      prev_done = done && rst_n;
    end
  end

  // Model of a load: bytes pair up low-first into words until the store is full.
  task automatic do_load(input bit collide);
    int n;
    load_start = 1'b1;
    start      = collide;
    tick();
    load_start = 1'b0;
    start      = 1'b0;
    model_done = 1'b0;
    check("busy_in_load", busy, 1);
    n = load_bytes.size();
    mw.delete();
    for (int i = 0; i + 1 < n && mw.size() < DEPTH; i += 2) begin
      mw.push_back({load_bytes[i+1], load_bytes[i]});
    end
    foreach (load_bytes[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        start = $urandom_range(0, 1);
        abort = ~start;
        tick();
        start = 1'b0;
        abort = 1'b0;
      end
      byte_in    = load_bytes[i];
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
    end
    load_done  = 1'b1;
    byte_valid = $urandom_range(0, 1);
    byte_in    = 8'($urandom);
    tick();
    load_done  = 1'b0;
    byte_valid = 1'b0;
    check("prog_len", prog_len, mw.size());
    check("overflow", overflow, (n > 2 * DEPTH) ? 1 : 0);
    check("busy_after_load", busy, 0);
  endtask

  task automatic do_run(input int hold_pct, input bit allow_abort);
    int  len, k;
    bit  h, ab;
    start = 1'b1;
    tick();
    start = 1'b0;
    len = mw.size();
    if (len == 0) begin
      if (!model_done) done_q.push_back(model_last);
      model_done = 1'b1;
      check("empty_start_done", done, 1);
      check("empty_start_valid", instr_valid, 0);
      return;
    end
    model_done = 1'b0;
    k = 0;
    while (k < len) begin
      ab = allow_abort && ($urandom_range(0, 99) < 5);
      h  = ($urandom_range(0, 99) < hold_pct);
      hold  = h;
      abort = ab;
      if (ab) begin
        tick();
        hold  = 1'b0;
        abort = 1'b0;
        check("abort_valid", instr_valid, 0);
        check("abort_done", done, 0);
        check("abort_pc", pc, 0);
        check("abort_busy", busy, 0);
        return;
      end
      if (!h) begin
        exp_q.push_back('{pc: AW'(k), w: mw[k]});
        model_last = core_f(mw[k]);
        k++;
        if (k == len) begin
          done_q.push_back(model_last);
          model_done = 1'b1;
        end
      end
      tick();
    end
    hold = 1'b0;
    check("done_after_run", done, 1);
    check("pc_final", pc, len - 1);
  endtask

  initial begin
    tick();
    tick();
    check("reset_state", {instr_out, instr_valid, pc, prog_len, last_result, busy, done, overflow}, 0);
    rst_n = 1'b1;
    tick();

    load_bytes = '{8'h34, 8'h12, 8'hCD, 8'hAB};
    do_load(1'b0);
    do_run(0, 1'b0);

    load_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    do_load(1'b0);
    do_run(0, 1'b0);

    load_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_load(1'b1);
    do_run(60, 1'b0);

    load_bytes.delete();
    do_load(1'b0);
    do_run(0, 1'b0);
    do_run(0, 1'b0);

    for (int ep = 0; ep < 30; ep++) begin
      load_bytes.delete();
      for (int i = 0; i < $urandom_range(0, 2 * DEPTH + 3); i++) begin
        load_bytes.push_back((ep % 4 == 0) ? {OPC_W, 6'($urandom)} : 8'($urandom));
      end
      do_load($urandom_range(0, 1));
      byte_valid = 1'b1;
      byte_in    = 8'($urandom);
      tick();
      byte_valid = 1'b0;
      check("byte_outside_load", prog_len, mw.size());
      do_run(30, 1'b1);
      if ($urandom_range(0, 1) == 1) do_run(20, 1'b1);
    end

    load_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    do_load(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back('{pc: AW'(0), w: mw[0]});
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("reset_mid_run", {instr_out, instr_valid, pc, prog_len, last_result, busy, done, overflow}, 0);
    mw.delete();
    model_last = '0;
    model_done = 1'b0;
    do_run(0, 1'b0);
    tick();
    tick();

    check("exp_queue_drained", exp_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Program sequencer that sits directly upstream of the 16-bit instruction-decode/ALU/register-file core.
- Accepts a program as a byte stream (low byte first, then high byte) and stores it in a small instruction memory.
- On command, replays the stored words to the core, one instruction per cycle.
- Captures the core's 8-bit result into a status register.
- Replaces hand-driving the core's 16 instruction pins every cycle.

Parameters:
DEPTH, 16, number of 16-bit instruction words stored (power of 2, 2..256)
AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
load_start  in  1  pulse: clear program, enter LOAD
load_done  in  1  pulse: leave LOAD
byte_in  in  8  program byte
byte_valid  in  1  byte_in valid this cycle
start  in  1  pulse: begin execution at word 0
hold  in  1  level: freeze RUN (no advance, no capture)
abort  in  1  pulse: terminate RUN
result_in  in  8  core result (combinational from instr_out)
instr_out  out  16  instruction to core; [7:0] = low byte
instr_valid  out  1  instr_out is live
pc  out  AW  index of word currently on instr_out
prog_len  out  AW+1  words stored
last_result  out  8  result_in sampled on last executed instruction
busy  out  1  state is LOAD or RUN
done  out  1  sticky: program completed
overflow  out  1  sticky: bytes dropped because memory was full

Behaviour:
- Reset (rst_n=0 at an edge) sets every output to 0: state IDLE, wr_ptr=0, phase=0, hold_byte=0, prog_len=0, pc=0, instr_out=0, instr_valid=0, last_result=0, busy=0, done=0, overflow=0.
- Memory contents are not reset; they are unreachable because prog_len=0.
- Reset mid-LOAD or mid-RUN behaves identically.
- States: IDLE, LOAD, RUN, DONE. busy = (LOAD|RUN).
- IDLE/DONE + load_start: wr_ptr=0, phase=0, prog_len=0, overflow=0, done=0; go to LOAD.
- LOAD + byte_valid, phase 0: hold_byte<=byte_in; phase<=1.
- LOAD + byte_valid, phase 1: mem[wr_ptr]<={byte_in,hold_byte}; wr_ptr++; prog_len++; phase<=0.
- LOAD + byte_valid while prog_len==DEPTH: byte dropped, overflow<=1.
- LOAD + load_done: go to IDLE; a pending half-word (phase 1) is discarded. load_done beats byte_valid in the same cycle.
- IDLE/DONE + start with prog_len>0: pc<=0, instr_out<=mem[0], instr_valid<=1, done<=0; go to RUN. First instruction is visible 1 cycle after start.
- IDLE/DONE + start with prog_len==0: go to DONE, done<=1, instr_valid stays 0.
- load_start and start in the same cycle: load_start wins.
- RUN, each edge with hold=0: last_result<=result_in.
  - If pc==prog_len-1: instr_out<=0, instr_valid<=0, done<=1, go to DONE.
  - Else: pc<=pc+1, instr_out<=mem[pc+1].
  - Throughput is 1 instruction/cycle; N instructions take N cycles.
- RUN with hold=1: all registers held.
- RUN + abort: instr_valid<=0, instr_out<=0, pc<=0, done stays 0; go to IDLE. abort has priority over hold and completion.
- Ignored: load_start/start in LOAD/RUN, byte_valid outside LOAD, abort outside RUN.
- DONE persists until the next load_start/start. pc holds its final value in DONE.
- instr_out changes only on clock edges (registered) so the core's combinational path starts clean each cycle.

Decomposition:
- Shared package: state enum (IDLE=0, LOAD=1, RUN=2, DONE=3), INSTR_W=16, RESULT_W=8, and opcode field constants (OPC_R=2'b00, OPC_I=2'b01, OPC_L=2'b10, OPC_W=2'b11) for benches and future decoders.
- One sub-module, instr_mem: DEPTH×16, synchronous write, asynchronous read, no reset.

Test Plan:
- Load bytes 34,12,CD,AB then load_done -> prog_len=2, overflow=0, state IDLE, busy=0.
- After that load, start with result_in=05 on the 1st instruction and 09 on the 2nd -> cycle+1 instr_out=1234 valid, pc=0; cycle+2 ABCD, pc=1; cycle+3 valid=0, done=1, last_result=09.
- DEPTH=4: load 10 bytes -> prog_len=4, overflow=1, mem holds first 8 bytes; odd byte then load_done -> half-word discarded.
- During RUN, assert hold 3 cycles on pc=1 -> instr_out/pc/last_result unchanged for 3 cycles, then resume; hold+abort same cycle -> IDLE, instr_valid=0, done=0.
- start with prog_len=0 -> no instr_valid, done=1 next cycle; start during LOAD -> ignored.
- rst_n=0 for one edge mid-RUN -> all outputs 0; subsequent start -> DONE immediately (prog_len=0).
